// File: rtl/instr_encode_loader_if.sv
// Instruction-field request channel and instruction-memory write port of the loader.
// The loader side uses the slave modport; the producer/memory side uses master.
interface instr_encode_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport slave (
    input  in_valid, op, funct3, funct7, rd, rs1, rs2, imm,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, op, funct3, funct7, rd, rs1, rs2, imm,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes RV32I instruction field sets into 32-bit words and streams them into
// instruction memory at consecutive word addresses from BASE_ADDR after each start.
module instr_encode_loader #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  instr_encode_loader_if.slave          bus,
  output logic [$clog2(DEPTH_WORDS):0]  count,
  output logic                          full,
  output logic                          err_illegal
);

  localparam int unsigned    CW      = $clog2(DEPTH_WORDS) + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH_WORDS);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
      OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL: ok = 1'b1;
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Fields a format does not use are simply not placed; imm[0] never reaches B/J words.
  function automatic logic [31:0] encode_word(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    case (op)
      OP_R:              w = {f7, rs2, rs1, f3, rd, op};
      OP_IMM: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          w = {f7, imm[4:0], rs1, f3, rd, op};
        end else begin
          w = {imm[11:0], rs1, f3, rd, op};
        end
      end
      OP_LOAD, OP_JALR:  w = {imm[11:0], rs1, f3, rd, op};
      OP_STORE:          w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      OP_BRANCH:         w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
      OP_LUI, OP_AUIPC:  w = {imm[31:12], rd, op};
      OP_JAL:            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
      default:           w = 32'd0;
    endcase
    return w;
  endfunction

  state_t         state_r;
  state_t         state_next_s;
  logic [CW-1:0]  cnt_r;
  logic           we_r;
  logic [31:0]    addr_r;
  logic [31:0]    wdata_r;
  logic           full_r;
  logic           err_r;
  logic           ready_s;
  logic           xfer_s;
  logic           legal_s;
  logic [31:0]    enc_s;

  // start blocks acceptance combinationally so it wins over a simultaneous in_valid.
  assign ready_s = (state_r == S_LOAD) && !start && (cnt_r < DEPTH_C);
  assign xfer_s  = bus.in_valid && ready_s;
  assign legal_s = is_legal(bus.op);
  assign enc_s   = encode_word(bus.op, bus.funct3, bus.funct7, bus.rd,
                               bus.rs1, bus.rs2, bus.imm);

  assign bus.in_ready   = ready_s;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign count          = cnt_r;
  assign full           = full_r;
  assign err_illegal    = err_r;

  // Next-state logic: start re-arms from any state; the last legal word fills memory.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (start) begin
          state_next_s = S_LOAD;
        end else if (xfer_s && legal_s && ((cnt_r + CW'(1)) == DEPTH_C)) begin
          state_next_s = S_FULL;
        end else begin
          state_next_s = S_LOAD;
        end
      end
      S_FULL: begin
        if (start) begin
          state_next_s = S_LOAD;
        end else begin
          state_next_s = S_FULL;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, word index and the registered write port; addr/wdata hold when no write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      we_r    <= 1'b0;
      addr_r  <= BASE_ADDR;
      wdata_r <= 32'd0;
      full_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      full_r  <= (state_next_s == S_FULL);
      if (start) begin
        cnt_r <= {CW{1'b0}};
        we_r  <= 1'b0;
        err_r <= 1'b0;
      end else if (xfer_s) begin
        if (legal_s) begin
          we_r    <= 1'b1;
          err_r   <= 1'b0;
          addr_r  <= BASE_ADDR + (32'(cnt_r) << 2);
          wdata_r <= enc_s;
          cnt_r   <= cnt_r + CW'(1);
        end else begin
          we_r  <= 1'b0;
          err_r <= 1'b1;
        end
      end else begin
        we_r  <= 1'b0;
        err_r <= 1'b0;
      end
    end
  end

endmodule
